adder_arbiter_ctrl: RTL and testbench

Two-channel request arbiter and sequencer for the pipelined 8-bit adder datapath (`dut_8bit_addr`). It accepts add requests from two clients with round-robin fairness and programs the adder's offset configuration registers through the descriptor (cfg) port only when needed. It then issues the operands, waits for the adder's ready strobe, and returns the result with a channel ID. The adder's `reset_n` is driven as `~rst` at the top level, so both blocks reset together.

---
 rtl/adder_arbiter_ctrl_if.sv | 32 +++
 rtl/adder_arbiter_ctrl.sv | 130 +++++++++++++
 tb/tb_adder_arbiter_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_ctrl_if.sv
// Request/response, adder datapath and descriptor (cfg) signals of adder_arbiter_ctrl.
// master = the arbiter/sequencer itself, slave = clients, consumer and adder around it.
interface adder_arbiter_ctrl_if;
  logic       req0_valid, req0_ready, req0_off_en;
  logic [7:0] req0_a, req0_b, req0_off;
  logic       req1_valid, req1_ready, req1_off_en;
  logic [7:0] req1_a, req1_b, req1_off;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
  logic [7:0] rsp_sum;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_val, add_carry, add_rdy;
  logic       cfg_req_valid, cfg_wr_rd;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_value;
  logic       busy;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_off_en, req0_off,
           req1_valid, req1_a, req1_b, req1_off_en, req1_off,
           rsp_ready, add_sum, add_carry, add_rdy,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err,
           add_a, add_b, add_val, cfg_req_valid, cfg_wr_rd, cfg_addr, cfg_value, busy
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_off_en, req0_off,
           req1_valid, req1_a, req1_b, req1_off_en, req1_off,
           rsp_ready, add_sum, add_carry, add_rdy,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err,
           add_a, add_b, add_val, cfg_req_valid, cfg_wr_rd, cfg_addr, cfg_value, busy
  );
endinterface

// File: rtl/adder_arbiter_ctrl.sv
// Two-channel round-robin arbiter/sequencer for the pipelined 8-bit adder: programs the
// adder's offset config only when its shadow copy differs, issues, waits, returns result.
module adder_arbiter_ctrl #(
  parameter int WAIT_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_arbiter_ctrl_if.master bus
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CFG_OFF, CFG_CTL, ISSUE, WAIT, CAPT, RESP} state_t;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       off_en;
    logic [7:0] off;
    logic       id;
  } req_t;

  state_t        state, nxt;
  req_t          cur, sel, src;
  logic          last_grant, gnt, gnt_id;
  logic [1:0]    vld;
  logic [7:0]    sh_ctl, sh_off;
  logic [CW-1:0] wait_cnt;

  assign vld = {bus.req1_valid, bus.req0_valid};

  always_comb begin
    gnt    = |vld;
    gnt_id = (vld == 2'b11) ? ~last_grant : vld[1];
    sel    = gnt_id ? {bus.req1_a, bus.req1_b, bus.req1_off_en, bus.req1_off, 1'b1}
                    : {bus.req0_a, bus.req0_b, bus.req0_off_en, bus.req0_off, 1'b0};
    src    = (state == IDLE) ? sel : cur;
  end

  assign bus.req0_ready = (state == IDLE) && gnt && !gnt_id;
  assign bus.req1_ready = (state == IDLE) && gnt &&  gnt_id;
  assign bus.busy       = (state != IDLE);

  // WAIT runs with the counter at 0..WAIT_MAX, so an abandoned add reports at t0+WAIT_MAX+3.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (gnt) begin
          if (sel.off_en && sh_off != sel.off)      nxt = CFG_OFF;
          else if (sh_ctl != {7'b0, sel.off_en})    nxt = CFG_CTL;
          else                                      nxt = ISSUE;
        end
      CFG_OFF: nxt = (sh_ctl != {7'b0, cur.off_en}) ? CFG_CTL : ISSUE;
      CFG_CTL: nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:
        if (bus.add_rdy)                    nxt = CAPT;
        else if (wait_cnt == CW'(WAIT_MAX)) nxt = RESP;
      CAPT:    nxt = RESP;
      RESP:    if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cur               <= '0;
      last_grant        <= 1'b1;
      sh_ctl            <= 8'h00;
      sh_off            <= 8'h00;
      wait_cnt          <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= 1'b0;
      bus.rsp_sum       <= 8'h00;
      bus.rsp_carry     <= 1'b0;
      bus.rsp_err       <= 1'b0;
      bus.add_a         <= 8'h00;
      bus.add_b         <= 8'h00;
      bus.add_val       <= 1'b0;
      bus.cfg_req_valid <= 1'b0;
      bus.cfg_wr_rd     <= 1'b0;
      bus.cfg_addr      <= 3'b000;
      bus.cfg_value     <= 8'h00;
    end else begin
      state             <= nxt;
      bus.cfg_req_valid <= 1'b0;
      bus.cfg_wr_rd     <= 1'b0;
      bus.add_val       <= 1'b0;
      if (state == IDLE && gnt) begin
        cur        <= sel;
        last_grant <= gnt_id;
      end
      if (state == WAIT && nxt == WAIT) wait_cnt <= wait_cnt + 1'b1;
      // Outputs are loaded on entry to each state so they line up with it.
      if (nxt != state) begin
        case (nxt)
          CFG_OFF: begin
            bus.cfg_req_valid <= 1'b1;
            bus.cfg_wr_rd     <= 1'b1;
            bus.cfg_addr      <= 3'b001;
            bus.cfg_value     <= src.off;
            sh_off            <= src.off;
          end
          CFG_CTL: begin
            bus.cfg_req_valid <= 1'b1;
            bus.cfg_wr_rd     <= 1'b1;
            bus.cfg_addr      <= 3'b000;
            bus.cfg_value     <= {7'b0, src.off_en};
            sh_ctl            <= {7'b0, src.off_en};
          end
          ISSUE: begin
            bus.add_a   <= src.a;
            bus.add_b   <= src.b;
            bus.add_val <= 1'b1;
          end
          WAIT: wait_cnt <= '0;
          RESP: begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur.id;
            bus.rsp_err   <= (state == WAIT);
            bus.rsp_sum   <= (state == WAIT) ? 8'h00 : bus.add_sum;
            bus.rsp_carry <= (state != WAIT) && bus.add_carry;
          end
          IDLE:    bus.rsp_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adder_arbiter_ctrl.sv
// Bench for adder_arbiter_ctrl: behavioural adder with its own config registers, plus a
// request-level model of config writes, latency and results.
module tb_adder_arbiter_ctrl;
  localparam int WAIT_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  adder_arbiter_ctrl_if bus();
  adder_arbiter_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder: Data_ready two cycles after Data_val is sampled; result held until the next one.
  logic [7:0] m_ctl, m_off, p_sum;
  logic       p_carry, p_pend;
  bit         stall = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_ctl <= 8'h00; m_off <= 8'h00; p_pend <= 1'b0;
      bus.add_rdy <= 1'b0; bus.add_sum <= 8'h00; bus.add_carry <= 1'b0;
    end else begin
      bus.add_rdy <= 1'b0;
      if (bus.cfg_req_valid && bus.cfg_wr_rd) begin
        if (bus.cfg_addr == 3'd0) m_ctl <= bus.cfg_value;
        else if (bus.cfg_addr == 3'd1) m_off <= bus.cfg_value;
      end
      p_pend <= bus.add_val;
      if (bus.add_val) begin
        p_sum   <= bus.add_a + bus.add_b + (m_ctl[0] ? m_off : 8'h00);
        p_carry <= ({1'b0, bus.add_a} + {1'b0, bus.add_b}) > 9'd255;
      end
      if (p_pend && !stall) begin
        bus.add_rdy <= 1'b1; bus.add_sum <= p_sum; bus.add_carry <= p_carry;
      end
    end
  end

  // Monitor samples 1 time unit after the falling edge, once the tasks have driven inputs.
  logic [11:0] cfgq[$];
  int          n_issue;
  logic [7:0]  iss_a, iss_b;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (bus.cfg_req_valid) cfgq.push_back({bus.cfg_wr_rd, bus.cfg_addr, bus.cfg_value});
      if (bus.add_val) begin n_issue++; iss_a = bus.add_a; iss_b = bus.add_b; end
    end
  end

  // Request-level model of what the adder has been configured with and who went last.
  logic [7:0] msh_off = 8'h00;
  bit         msh_on = 0;
  int         m_last = 1;

  task automatic drive(input int ch, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic oe, input logic [7:0] off);
    if (ch == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_off_en = oe; bus.req0_off = off;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_off_en = oe; bus.req1_off = off;
    end
  endtask

  task automatic check_zero(input string nm);
    logic [44:0] o;
    o = {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_err, bus.add_a, bus.add_b,
         bus.add_val, bus.cfg_req_valid, bus.cfg_wr_rd, bus.cfg_addr, bus.cfg_value, bus.busy,
         bus.req0_ready, bus.req1_ready};
    tests++;
    if (o !== 45'd0) begin fails++; $display("FAIL %s: outputs got %h want 0", nm, o); end
  endtask

  // One full transaction on channel ch; hold = cycles rsp_ready stays low in RESP.
  task automatic do_req(input int ch, input logic [7:0] a, input logic [7:0] b,
                        input logic oe, input logic [7:0] off, input int hold);
    logic [11:0] expq[$];
    logic [7:0]  es;
    logic        ec, rdy, rdy_o;
    int          t0, lat, exp_lat;
    logic [10:0] snap;
    es = a + b + (oe ? off : 8'h00);
    ec = (int'(a) + int'(b)) > 255;
    if (stall) begin es = 8'h00; ec = 1'b0; end
    if (oe && msh_off != off) begin expq.push_back({1'b1, 3'd1, off}); msh_off = off; end
    if (msh_on != oe) begin expq.push_back({1'b1, 3'd0, 7'd0, oe}); msh_on = oe; end
    exp_lat = (stall ? WAIT_MAX + 3 : 5) + expq.size();
    cfgq.delete(); n_issue = 0;
    @(negedge clk); drive(ch, 1'b1, a, b, oe, off); #1;
    rdy = 1'b0; rdy_o = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy   = (ch == 0) ? bus.req0_ready : bus.req1_ready;
      rdy_o = (ch == 0) ? bus.req1_ready : bus.req0_ready;
      if (rdy) break;
      @(negedge clk); #1;
    end
    t0 = cyc;
    tests++;
    if (rdy !== 1'b1 || rdy_o !== 1'b0) begin
      fails++; $display("FAIL grant ch%0d: ready got %b/%b want 1/0", ch, rdy, rdy_o);
    end
    m_last = ch;
    @(negedge clk); drive(ch, 1'b0, a, b, oe, off); #1;
    for (int i = 0; i < 40 && bus.rsp_valid !== 1'b1; i++) begin @(negedge clk); #1; end
    lat = cyc - t0;
    tests++;
    if (bus.rsp_valid !== 1'b1) begin
      fails++; $display("FAIL rsp_timeout ch%0d: rsp_valid got %b want 1", ch, bus.rsp_valid);
      return;
    end
    tests++;
    if (lat != exp_lat) begin fails++; $display("FAIL latency: got %0d want %0d", lat, exp_lat); end
    tests++;
    if (bus.rsp_id !== ch[0]) begin fails++; $display("FAIL rsp_id: got %b want %0d", bus.rsp_id, ch); end
    tests++;
    if (bus.rsp_sum !== es) begin fails++; $display("FAIL rsp_sum: got %h want %h", bus.rsp_sum, es); end
    tests++;
    if (bus.rsp_carry !== ec) begin fails++; $display("FAIL rsp_carry: got %b want %b", bus.rsp_carry, ec); end
    tests++;
    if (bus.rsp_err !== stall) begin fails++; $display("FAIL rsp_err: got %b want %b", bus.rsp_err, stall); end
    tests++;
    if (cfgq.size() != expq.size()) begin
      fails++; $display("FAIL cfg_count: got %0d want %0d", cfgq.size(), expq.size());
    end else begin
      foreach (expq[k]) begin
        tests++;
        if (cfgq[k] !== expq[k]) begin fails++; $display("FAIL cfg_write%0d: got %h want %h", k, cfgq[k], expq[k]); end
      end
    end
    tests++;
    if (n_issue != 1 || iss_a !== a || iss_b !== b) begin
      fails++; $display("FAIL issue: got n=%0d %h/%h want n=1 %h/%h", n_issue, iss_a, iss_b, a, b);
    end
    snap = {bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_err};
    if (hold > 0) drive(1 - ch, 1'b1, ~a, ~b, 1'b0, 8'h00);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      tests++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_err} !== snap
          || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        fails++; $display("FAIL resp_hold%0d: got v=%b %h r=%b%b want v=1 %h r=00", k, bus.rsp_valid,
                          {bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_err}, bus.req1_ready, bus.req0_ready, snap);
      end
    end
    drive(1 - ch, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL rsp_drop: got valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1; check_zero("in_reset");
    rst = 1'b0;
    @(negedge clk); #1; check_zero("after_reset");
  endtask

  task automatic test_basic();
    do_req(0, 8'h3C, 8'h55, 1'b0, 8'h00, 0);
    do_req(1, 8'hF0, 8'h20, 1'b0, 8'h00, 0);
  endtask

  task automatic test_offset();
    do_req(0, 8'h10, 8'h01, 1'b1, 8'h05, 0);
    do_req(0, 8'h10, 8'h01, 1'b1, 8'h05, 0);
    do_req(0, 8'h10, 8'h01, 1'b0, 8'h05, 0);
  endtask

  task automatic test_timeout();
    stall = 1;
    do_req(1, 8'hAA, 8'h77, 1'b0, 8'h00, 0);
    stall = 0;
  endtask

  task automatic test_backpressure();
    do_req(1, 8'h81, 8'h90, 1'b0, 8'h00, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      logic [7:0] off;
      off = ($urandom_range(0, 1) == 1) ? 8'h05 : 8'($urandom);
      do_req(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom),
             off, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    int g[4];
    int gc[4];
    int ng, both;
    logic r0, r1;
    ng = 0; both = 0;
    if (msh_on) do_req(0, 8'h01, 8'h02, 1'b0, 8'h00, 0);
    cfgq.delete();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 8'h11, 8'h22, 1'b0, 8'h00);
    drive(1, 1'b1, 8'h33, 8'h44, 1'b0, 8'h00);
    #1;
    for (int i = 0; i < 80; i++) begin
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      if (r0 && r1) both++;
      if (r0 || r1) begin g[ng] = r1 ? 1 : 0; gc[ng] = cyc; ng++; end
      if (ng == 4) break;
      @(negedge clk); #1;
    end
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    bus.rsp_ready = 1'b0;
    tests++;
    if (ng != 4) begin
      fails++; $display("FAIL b2b_grants: got %0d want 4", ng);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (g[k] != ((1 - m_last + k) % 2)) begin
          fails++; $display("FAIL b2b_order%0d: got %0d want %0d", k, g[k], (1 - m_last + k) % 2);
        end
      end
      for (int k = 1; k < 4; k++) begin
        tests++;
        if (gc[k] - gc[k-1] != 6) begin fails++; $display("FAIL b2b_gap%0d: got %0d want 6", k, gc[k] - gc[k-1]); end
      end
      m_last = g[2];
    end
    tests++;
    if (both != 0 || cfgq.size() != 0) begin
      fails++; $display("FAIL b2b_side: got both=%0d cfg=%0d want 0/0", both, cfgq.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic r0, r1, seen;
    stall = 1;
    @(negedge clk); drive(0, 1'b1, 8'h12, 8'h34, 1'b1, 8'h22); #1;
    for (int i = 0; i < 20 && bus.req0_ready !== 1'b1; i++) begin @(negedge clk); #1; end
    t0 = cyc;
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00); #1;
    for (int i = 0; i < 20 && cyc < t0 + 6; i++) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    check_zero("reset_in_wait");
    rst = 1'b0; stall = 0;
    msh_off = 8'h00; msh_on = 0; m_last = 1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); #1; if (bus.rsp_valid) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_rsp: got rsp_valid=1 want 0"); end
    drive(0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
    drive(1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
    #1;
    r0 = bus.req0_ready; r1 = bus.req1_ready;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    tests++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin fails++; $display("FAIL reset_first_grant: got %b%b want 01", r1, r0); end
    do_req(0, 8'h12, 8'h34, 1'b1, 8'h22, 0);
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_offset();
    test_timeout();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
